// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types: memory FSM states and the control bundle
package cpu_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   // Control bundle carried by ID/EX, EX/MEM and MEM/WB alike
   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   function automatic logic is_mem_op(input ctrl_t c);
      return c.mem_read | c.mem_write;
   endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// rtl/mem_req_fsm.sv - data-memory request FSM with timeout counter
// Drives req/stall for the EX/MEM slot and flags aborted or misaligned accesses.
module mem_req_fsm
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16
)
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic mem_op_i,
   input  logic aligned_i,
   input  logic ack_i,
   output logic req_o,
   output logic stall_o,
   output logic abort_o,
   output logic misalign_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timed_out;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The abort cycle drops the request, so stall never exceeds TIMEOUT cycles
   assign timed_out = (state_q == WAIT) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_o && !ack_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (timed_out || ack_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      req_o      = mem_op_i && aligned_i && !timed_out;
      stall_o    = req_o && !ack_i;
      abort_o    = mem_op_i && timed_out;
      misalign_o = mem_op_i && !aligned_i;
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM register, data-memory access and MEM/WB register
// Exports the EX/MEM slot for forwarding and stalls upstream during memory waits.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 16
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic              mem_to_reg_i,
   input  logic              reg_write_i,
   output logic              stall_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [DATA_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   input  logic              dmem_ack_i,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   output logic [REG_AW-1:0] fwd_rd_o,
   output logic              fwd_we_o,
   output logic [DATA_W-1:0] fwd_data_o,
   output logic              wb_valid_o,
   output logic [REG_AW-1:0] wb_rd_o,
   output logic              wb_we_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              err_o
);

   logic              exm_valid_q, exm_valid_d;
   ctrl_t             exm_ctrl_q, exm_ctrl_d;
   logic [DATA_W-1:0] exm_result_q, exm_result_d;
   logic [DATA_W-1:0] exm_wdata_q, exm_wdata_d;
   logic [REG_AW-1:0] exm_rd_q, exm_rd_d;

   logic              wb_valid_q, wb_valid_d;
   logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
   logic              wb_we_q, wb_we_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic mem_op, aligned, req, abort, misalign, completed;

   assign mem_op  = exm_valid_q && is_mem_op(exm_ctrl_q);
   assign aligned = (exm_result_q[1:0] == 2'b00);

   mem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .mem_op_i   (mem_op),
      .aligned_i  (aligned),
      .ack_i      (dmem_ack_i),
      .req_o      (req),
      .stall_o    (stall_o),
      .abort_o    (abort),
      .misalign_o (misalign)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         exm_valid_q  <= 1'b0;
         exm_ctrl_q   <= ctrl_t'({CTRL_W{1'b0}});
         exm_result_q <= '0;
         exm_wdata_q  <= '0;
         exm_rd_q     <= '0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_we_q      <= 1'b0;
         wb_data_q    <= '0;
      end else begin
         exm_valid_q  <= exm_valid_d;
         exm_ctrl_q   <= exm_ctrl_d;
         exm_result_q <= exm_result_d;
         exm_wdata_q  <= exm_wdata_d;
         exm_rd_q     <= exm_rd_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_we_q      <= wb_we_d;
         wb_data_q    <= wb_data_d;
      end
   end

   // Bubbles are fully zeroed so forwarding and WB never see stale fields
   always_comb begin
      exm_valid_d  = exm_valid_q;
      exm_ctrl_d   = exm_ctrl_q;
      exm_result_d = exm_result_q;
      exm_wdata_d  = exm_wdata_q;
      exm_rd_d     = exm_rd_q;
      if (!stall_o) begin
         if (valid_i && !flush_i) begin
            exm_valid_d  = 1'b1;
            exm_ctrl_d   = '{mem_read:   mem_read_i,
                             mem_write:  mem_write_i,
                             mem_to_reg: mem_to_reg_i,
                             reg_write:  reg_write_i};
            exm_result_d = alu_result_i;
            exm_wdata_d  = store_data_i;
            exm_rd_d     = rd_i;
         end else begin
            exm_valid_d  = 1'b0;
            exm_ctrl_d   = ctrl_t'({CTRL_W{1'b0}});
            exm_result_d = '0;
            exm_wdata_d  = '0;
            exm_rd_d     = '0;
         end
      end
   end

   assign completed = exm_valid_q && (!mem_op || (req && dmem_ack_i));

   always_comb begin
      wb_valid_d = 1'b0;
      wb_rd_d    = '0;
      wb_we_d    = 1'b0;
      wb_data_d  = '0;
      if (completed) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = exm_rd_q;
         wb_we_d    = exm_ctrl_q.reg_write && !exm_ctrl_q.mem_write;
         wb_data_d  = exm_ctrl_q.mem_to_reg ? dmem_rdata_i : exm_result_q;
      end
   end

   assign dmem_req_o   = req;
   assign dmem_we_o    = req && exm_ctrl_q.mem_write;
   assign dmem_addr_o  = {exm_result_q[DATA_W-1:2], 2'b00};
   assign dmem_wdata_o = exm_wdata_q;
   assign err_o        = abort || misalign;

   assign fwd_rd_o   = exm_rd_q;
   assign fwd_we_o   = exm_valid_q && exm_ctrl_q.reg_write && !exm_ctrl_q.mem_read;
   assign fwd_data_o = exm_result_q;

   assign wb_valid_o = wb_valid_q;
   assign wb_rd_o    = wb_rd_q;
   assign wb_we_o    = wb_we_q;
   assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
// Slot-level reference model compared every cycle, plus directed literal checks.
module tb_mem_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i, valid_i, flush_i;
   logic [DW-1:0] alu_result_i, store_data_i, dmem_rdata_i;
   logic [AW-1:0] rd_i;
   logic          mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i, dmem_ack_i;
   logic          stall_o, dmem_req_o, dmem_we_o, fwd_we_o, wb_valid_o, wb_we_o, err_o;
   logic [DW-1:0] dmem_addr_o, dmem_wdata_o, fwd_data_o, wb_data_o;
   logic [AW-1:0] fwd_rd_o, wb_rd_o;

   mem_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
      .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_i(rd_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
      .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
      .fwd_rd_o(fwd_rd_o), .fwd_we_o(fwd_we_o), .fwd_data_o(fwd_data_o),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o),
      .wb_data_o(wb_data_o), .err_o(err_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: one EX/MEM slot, how many request cycles it has waited, and the WB slot
   typedef struct {
      bit            v, mr, mw, m2r, rw;
      logic [DW-1:0] res, sd;
      logic [AW-1:0] rd;
   } slot_t;

   slot_t         s;
   int            waited = 0;
   bit            m_wv = 0, m_wwe = 0;
   logic [AW-1:0] m_wrd = '0;
   logic [DW-1:0] m_wdata = '0;
   bit            armed = 0;
   bit            mop, al, e_req, e_stall, e_err, done;
   int            stall_cnt = 0, err_cnt = 0, req_cnt = 0, wbv_cnt = 0;

   initial begin
      s = '{v: 0, mr: 0, mw: 0, m2r: 0, rw: 0, res: '0, sd: '0, rd: '0};
   end

   always @(negedge clk) begin
      if (armed) begin
         mop     = s.v && (s.mr || s.mw);
         al      = (s.res % 4) == 0;
         e_req   = mop && al && (waited < TO);
         e_stall = e_req && !dmem_ack_i;
         e_err   = mop && (!al || waited >= TO);

         chk("req", 64'(dmem_req_o), 64'(e_req));
         chk("stall", 64'(stall_o), 64'(e_stall));
         chk("err", 64'(err_o), 64'(e_err));
         if (e_req) begin
            chk("dmem_we", 64'(dmem_we_o), 64'(s.mw));
            chk("dmem_addr", 64'(dmem_addr_o), 64'(s.res));
            chk("dmem_wdata", 64'(dmem_wdata_o), 64'(s.sd));
         end
         chk("fwd_we", 64'(fwd_we_o), 64'(s.v && s.rw && !s.mr));
         if (s.v) begin
            chk("fwd_rd", 64'(fwd_rd_o), 64'(s.rd));
            chk("fwd_data", 64'(fwd_data_o), 64'(s.res));
         end
         chk("wb_valid", 64'(wb_valid_o), 64'(m_wv));
         chk("wb_we", 64'(wb_we_o), 64'(m_wwe));
         if (m_wv) begin
            chk("wb_rd", 64'(wb_rd_o), 64'(m_wrd));
            chk("wb_data", 64'(wb_data_o), 64'(m_wdata));
         end

         stall_cnt += int'(stall_o);
         err_cnt   += int'(err_o);
         req_cnt   += int'(dmem_req_o);
         wbv_cnt   += int'(wb_valid_o);

         if (rst_i) begin
            s = '{v: 0, mr: 0, mw: 0, m2r: 0, rw: 0, res: '0, sd: '0, rd: '0};
            waited = 0;
            m_wv = 0; m_wwe = 0; m_wrd = '0; m_wdata = '0;
         end else begin
            done    = s.v && (!mop || (e_req && dmem_ack_i));
            m_wv    = done;
            m_wwe   = done && s.rw && !s.mw;
            m_wrd   = done ? s.rd : '0;
            m_wdata = done ? (s.m2r ? dmem_rdata_i : s.res) : '0;
            if (e_stall) begin
               waited++;
            end else begin
               waited = 0;
               if (valid_i && !flush_i)
                  s = '{v: 1, mr: mem_read_i, mw: mem_write_i, m2r: mem_to_reg_i,
                        rw: reg_write_i, res: alu_result_i, sd: store_data_i, rd: rd_i};
               else
                  s = '{v: 0, mr: 0, mw: 0, m2r: 0, rw: 0, res: '0, sd: '0, rd: '0};
            end
         end
      end
   end

   task automatic step(input bit r, input bit v, input bit f, input logic [DW-1:0] a,
                       input logic [DW-1:0] sd, input logic [AW-1:0] rd, input bit mr,
                       input bit mw, input bit m2r, input bit rw, input bit ack,
                       input logic [DW-1:0] rdata);
      rst_i = r; valid_i = v; flush_i = f; alu_result_i = a; store_data_i = sd; rd_i = rd;
      mem_read_i = mr; mem_write_i = mw; mem_to_reg_i = m2r; reg_write_i = rw;
      dmem_ack_i = ack; dmem_rdata_i = rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ack = 0, input logic [DW-1:0] rdata = 32'hDEAD_BEEF);
      repeat (n) step(0, 0, 0, '0, '0, '0, 0, 0, 0, 0, ack, rdata);
   endtask

   task automatic load(input logic [AW-1:0] rd, input logic [DW-1:0] a, input bit ack = 0,
                       input logic [DW-1:0] rdata = '0);
      step(0, 1, 0, a, '0, rd, 1, 0, 1, 1, ack, rdata);
   endtask

   function automatic logic any_out();
      return |{stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, fwd_rd_o, fwd_we_o,
               fwd_data_o, wb_valid_o, wb_rd_o, wb_we_o, wb_data_o, err_o};
   endfunction

   int b_stall, b_err, b_req, b_wbv;

   task automatic mark();
      b_stall = stall_cnt; b_err = err_cnt; b_req = req_cnt; b_wbv = wbv_cnt;
   endtask

   initial begin
      rst_i = 1; valid_i = 0; flush_i = 0; alu_result_i = '0; store_data_i = '0; rd_i = '0;
      mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0; reg_write_i = 0;
      dmem_ack_i = 0; dmem_rdata_i = '0;
      @(posedge clk);
      armed = 1;
      #1;
      step(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, '0);
      chk("reset_all_zero", 64'(any_out()), 64'(0));
      idle(2);

      // ALU op r5 = 0x1234
      mark();
      step(0, 1, 0, 32'h1234, '0, 5'd5, 0, 0, 0, 1, 0, '0);
      chk("alu_fwd_data", 64'(fwd_data_o), 64'h1234);
      idle(1);
      chk("alu_wb_we", 64'(wb_we_o), 64'(1));
      chk("alu_wb_rd", 64'(wb_rd_o), 64'(5));
      chk("alu_wb_data", 64'(wb_data_o), 64'h1234);
      chk("alu_no_stall", 64'(stall_cnt - b_stall), 64'(0));

      // Load 0x40, ack after three wait cycles
      idle(1);
      mark();
      load(5'd8, 32'h40);
      chk("ld_addr_first", 64'(dmem_addr_o), 64'h40);
      idle(2);
      chk("ld_addr_held", 64'(dmem_addr_o), 64'h40);
      idle(1);
      idle(1, 1, 32'hCAFE_F00D);
      chk("ld_stall_cycles", 64'(stall_cnt - b_stall), 64'(3));
      chk("ld_wb_data", 64'(wb_data_o), 64'hCAFE_F00D);
      chk("ld_wb_we", 64'(wb_we_o), 64'(1));
      chk("ld_wb_rd", 64'(wb_rd_o), 64'(8));

      // Store 0x44 then load 0x48, both zero-wait
      idle(1);
      mark();
      step(0, 1, 0, 32'h44, 32'h55, '0, 0, 1, 0, 0, 0, '0);
      load(5'd3, 32'h48, 1, 32'h0BAD_0BAD);
      chk("st_wb_valid", 64'(wb_valid_o), 64'(1));
      chk("st_wb_we", 64'(wb_we_o), 64'(0));
      idle(1, 1, 32'h1234_5678);
      chk("b2b_ld_data", 64'(wb_data_o), 64'h1234_5678);
      chk("b2b_ld_rd", 64'(wb_rd_o), 64'(3));
      chk("b2b_req_cycles", 64'(req_cnt - b_req), 64'(2));
      chk("b2b_no_stall", 64'(stall_cnt - b_stall), 64'(0));
      idle(1);

      // Misaligned load 0x42
      mark();
      load(5'd4, 32'h42);
      idle(1);
      chk("mis_err_pulses", 64'(err_cnt - b_err), 64'(1));
      chk("mis_no_req", 64'(req_cnt - b_req), 64'(0));
      chk("mis_wb_we", 64'(wb_we_o), 64'(0));
      chk("mis_wb_valid", 64'(wb_valid_o), 64'(0));

      // Load that is never acked, then late acks in IDLE, then the pipeline resumes
      idle(1);
      mark();
      load(5'd6, 32'h80);
      idle(17);
      idle(2, 1, 32'h7777_7777);
      idle(1);
      chk("to_stall_cycles", 64'(stall_cnt - b_stall), 64'(TO));
      chk("to_err_pulses", 64'(err_cnt - b_err), 64'(1));
      chk("to_no_wb", 64'(wbv_cnt - b_wbv), 64'(0));
      step(0, 1, 0, 32'h77, '0, 5'd7, 0, 0, 0, 1, 0, '0);
      idle(1);
      chk("resume_wb_data", 64'(wb_data_o), 64'h77);
      chk("resume_wb_rd", 64'(wb_rd_o), 64'(7));

      // Reset during WAIT
      idle(1);
      mark();
      load(5'd9, 32'h100);
      idle(2);
      chk("rw_req_before", 64'(dmem_req_o), 64'(1));
      step(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, 0, '0);
      chk("rw_all_zero", 64'(any_out()), 64'(0));
      idle(3, 1, 32'h9999_9999);
      chk("rw_no_wb", 64'(wbv_cnt - b_wbv), 64'(0));

      // Flushed load never requests
      mark();
      step(0, 1, 1, 32'h200, '0, 5'd10, 1, 0, 1, 1, 0, '0);
      chk("fl_all_zero", 64'(any_out()), 64'(0));
      idle(2);
      chk("fl_no_req", 64'(req_cnt - b_req), 64'(0));
      chk("fl_no_wb", 64'(wbv_cnt - b_wbv), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
